inst_axi_rd_bridge: RTL and testbench

Converts the instruction-fetch SRAM-like request/addr_ok/data_ok protocol, driven by the pre-IF/IF stages, into single-beat AXI4 read transactions on the instruction port. It sits directly upstream of the fetch stage. It accepts fetch addresses into a registered AR slot and tracks outstanding reads with a counter. R-channel data returns to the fetch stage in issue order as a one-cycle data_ok pulse. Instruction-side only: no writes, no data cache.

---
 rtl/inst_axi_rd_bridge_if.sv | 56 +++++
 rtl/inst_axi_rd_bridge.sv | 106 ++++++++++
 tb/tb_inst_axi_rd_bridge.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_axi_rd_bridge_if.sv
// Fetch-side SRAM-like request port plus AXI4 AR/R channels of inst_axi_rd_bridge.
// IBRIDGE_RRESP_ERR_EN adds inst_sram_rerr and bus_err_sticky.
interface inst_axi_rd_bridge_if;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
`ifdef IBRIDGE_RRESP_ERR_EN
    logic        inst_sram_rerr;
    logic        bus_err_sticky;
`endif
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    // master: the bridge; slave: fetch stage and AXI slave together
    modport master (
`ifdef IBRIDGE_RRESP_ERR_EN
        output inst_sram_rerr, bus_err_sticky,
`endif
        input  inst_sram_req, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        output arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
`ifdef IBRIDGE_RRESP_ERR_EN
        input  inst_sram_rerr, bus_err_sticky,
`endif
        output inst_sram_req, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        input  arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch SRAM-like to single-beat AXI4 read bridge with in-order returns.
// IBRIDGE_RRESP_ERR_EN adds the rerr pulse and a sticky bus-error flag.
module inst_axi_rd_bridge #(
    parameter logic [3:0]  ARID_VAL = 4'h0,
    parameter int unsigned MAX_OUT  = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    inst_axi_rd_bridge_if.master bus
);

    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        AR_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      araddr_q, araddr_d;
    logic             accept_c;
    logic             ret_c;

    // Next-state, address capture and outstanding-count update
    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        accept_c = 1'b0;
        cnt_d    = cnt_q;
        ret_c    = bus.rvalid && (cnt_q != '0) && bus.rlast;
        case (state_q)
            IDLE: begin
                accept_c = bus.inst_sram_req && (cnt_q < CNT_W'(MAX_OUT));
                if (accept_c) begin
                    araddr_d = bus.inst_sram_addr;
                    state_d  = AR_BUSY;
                end
            end
            AR_BUSY: begin
                if (bus.arready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        case ({accept_c, ret_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            araddr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            araddr_q <= araddr_d;
        end
    end

    assign bus.arid    = ARID_VAL;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'b0000;
    assign bus.arprot  = 3'b000;
    assign bus.araddr  = araddr_q;
    assign bus.arvalid = (state_q == AR_BUSY);
    assign bus.rready  = (cnt_q != '0);

    // Accept and return strobes are combinational to keep the 2-cycle fetch latency
    assign bus.inst_sram_addr_ok = accept_c;
    assign bus.inst_sram_data_ok = ret_c;
    assign bus.inst_sram_rdata   = bus.rdata;

`ifdef IBRIDGE_RRESP_ERR_EN
    logic rerr_c;
    logic sticky_q;

    assign rerr_c             = ret_c && (bus.rresp != 2'b00);
    assign bus.inst_sram_rerr = rerr_c;
    assign bus.bus_err_sticky = sticky_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sticky_q <= 1'b0;
        end else if (rerr_c) begin
            sticky_q <= 1'b1;
        end
    end

    // Single ID in flight, so rid carries no information
    logic unused_rid;
    assign unused_rid = ^bus.rid;
`else
    logic unused_rbits;
    assign unused_rbits = ^{bus.rid, bus.rresp};
`endif

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed and randomized bench for inst_axi_rd_bridge against a queue-based fetch/AXI model.
// Also exercises the IBRIDGE_RRESP_ERR_EN ports when that macro is defined.
module tb_inst_axi_rd_bridge;

    localparam int unsigned MAX_OUT   = 2;
    localparam logic [3:0]  ARID_VAL  = 4'h5;
    localparam logic [31:0] DATA_MASK = 32'h5A5A_0001;

    logic clk = 1'b0;
    logic resetn;
    int   tests = 0;
    int   fails = 0;

    inst_axi_rd_bridge_if bus ();

    inst_axi_rd_bridge #(
        .ARID_VAL (ARID_VAL),
        .MAX_OUT  (MAX_OUT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic req, input logic [31:0] addr, input logic arready,
                         input logic rvalid, input logic [31:0] rdata, input logic [1:0] rresp);
        @(negedge clk);
        bus.inst_sram_req  = req;
        bus.inst_sram_addr = addr;
        bus.arready        = arready;
        bus.rvalid         = rvalid;
        bus.rdata          = rdata;
        bus.rresp          = rresp;
        bus.rlast          = 1'b1;
        bus.rid            = 4'($urandom_range(0, 15));
        #1;
    endtask

    logic        req_r, arr_r, rv_r, exp_ok, exp_dok, m_pend;
    logic [31:0] a_r, rd_r, m_addr;
    logic [1:0]  rs_r;
    int          m_cnt;
    logic [31:0] acc_q[$];
    logic [31:0] ar_q[$];
`ifdef IBRIDGE_RRESP_ERR_EN
    logic        m_sticky;
`endif

    initial begin
        resetn = 1'b0;
        bus.inst_sram_req = 1'b0; bus.inst_sram_addr = '0; bus.arready = 1'b0;
        bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.rid = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;

        // Reset state and constant AR payload
        chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
        chk("rst_rready", 32'(bus.rready), 32'd0);
        chk("rst_addr_ok", 32'(bus.inst_sram_addr_ok), 32'd0);
        chk("rst_data_ok", 32'(bus.inst_sram_data_ok), 32'd0);
        chk("rst_araddr", bus.araddr, 32'd0);
        chk("arid", 32'(bus.arid), 32'(ARID_VAL));
        chk("arlen", 32'(bus.arlen), 32'd0);
        chk("arsize", 32'(bus.arsize), 32'd2);
        chk("arburst", 32'(bus.arburst), 32'd1);
        chk("arlock_cache_prot", 32'({bus.arlock, bus.arcache, bus.arprot}), 32'd0);
`ifdef IBRIDGE_RRESP_ERR_EN
        chk("rst_sticky", 32'(bus.bus_err_sticky), 32'd0);
`endif

        // Single fetch: accept, AR, R on consecutive cycles
        drive(1'b1, 32'h1c00_0000, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("sf_addr_ok", 32'(bus.inst_sram_addr_ok), 32'd1);
        chk("sf_arvalid0", 32'(bus.arvalid), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("sf_arvalid1", 32'(bus.arvalid), 32'd1);
        chk("sf_araddr", bus.araddr, 32'h1c00_0000);
        chk("sf_rready", 32'(bus.rready), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0280_0000, 2'b00);
        chk("sf_data_ok", 32'(bus.inst_sram_data_ok), 32'd1);
        chk("sf_rdata", bus.inst_sram_rdata, 32'h0280_0000);
        chk("sf_arvalid2", 32'(bus.arvalid), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00);
        chk("sf_data_ok_pulse", 32'(bus.inst_sram_data_ok), 32'd0);
        chk("sf_rready_idle", 32'(bus.rready), 32'd0);

        // AR backpressure: payload held, no new accepts
        drive(1'b1, 32'h1c00_0040, 1'b0, 1'b0, 32'h0, 2'b00);
        chk("bp_addr_ok", 32'(bus.inst_sram_addr_ok), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1c00_0080 + 32'(i * 4), 1'b0, 1'b0, 32'h0, 2'b00);
            chk("bp_arvalid", 32'(bus.arvalid), 32'd1);
            chk("bp_araddr", bus.araddr, 32'h1c00_0040);
            chk("bp_addr_ok_hold", 32'(bus.inst_sram_addr_ok), 32'd0);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("bp_hs_arvalid", 32'(bus.arvalid), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0001, 2'b00);
        chk("bp_data_ok", 32'(bus.inst_sram_data_ok), 32'd1);

        // Outstanding limit with MAX_OUT = 2
        drive(1'b1, 32'h0000_1000, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("lim_acc1", 32'(bus.inst_sram_addr_ok), 32'd1);
        drive(1'b1, 32'h0000_2000, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("lim_busy", 32'(bus.inst_sram_addr_ok), 32'd0);
        drive(1'b1, 32'h0000_2000, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("lim_acc2", 32'(bus.inst_sram_addr_ok), 32'd1);
        drive(1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0, 2'b00);
        drive(1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("lim_stall", 32'(bus.inst_sram_addr_ok), 32'd0);
        chk("lim_stall_rready", 32'(bus.rready), 32'd1);
        drive(1'b1, 32'h0000_3000, 1'b1, 1'b1, 32'h1111_1111, 2'b00);
        chk("lim_ret_data_ok", 32'(bus.inst_sram_data_ok), 32'd1);
        chk("lim_ret_addr_ok", 32'(bus.inst_sram_addr_ok), 32'd0);
        drive(1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("lim_acc3", 32'(bus.inst_sram_addr_ok), 32'd1);
        drive(1'b1, 32'h0000_4000, 1'b1, 1'b0, 32'h0, 2'b00);
        drive(1'b1, 32'h0000_4000, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("lim_full_again", 32'(bus.inst_sram_addr_ok), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_2222, 2'b00);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h3333_3333, 2'b00);
        chk("lim_drain", 32'(bus.inst_sram_data_ok), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00);
        chk("lim_empty", 32'(bus.rready), 32'd0);

        // Simultaneous accept and return leaves the count unchanged
        drive(1'b1, 32'h0000_5000, 1'b1, 1'b0, 32'h0, 2'b00);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00);
        drive(1'b1, 32'h0000_6000, 1'b0, 1'b1, 32'h4444_4444, 2'b00);
        chk("sim_addr_ok", 32'(bus.inst_sram_addr_ok), 32'd1);
        chk("sim_data_ok", 32'(bus.inst_sram_data_ok), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("sim_rready", 32'(bus.rready), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_5555, 2'b00);
        chk("sim_ret", 32'(bus.inst_sram_data_ok), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00);
        chk("sim_cnt_zero", 32'(bus.rready), 32'd0);

`ifdef IBRIDGE_RRESP_ERR_EN
        // Error response sets the sticky flag
        drive(1'b1, 32'h0000_7000, 1'b1, 1'b0, 32'h0, 2'b00);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h6666_6666, 2'b10);
        chk("err_rerr", 32'(bus.inst_sram_rerr), 32'd1);
        chk("err_data_ok", 32'(bus.inst_sram_data_ok), 32'd1);
        chk("err_sticky_pre", 32'(bus.bus_err_sticky), 32'd0);
        drive(1'b1, 32'h0000_8000, 1'b1, 1'b0, 32'h0, 2'b10);
        chk("err_rerr_pulse", 32'(bus.inst_sram_rerr), 32'd0);
        chk("err_sticky", 32'(bus.bus_err_sticky), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_7777, 2'b00);
        chk("err_ok_rerr", 32'(bus.inst_sram_rerr), 32'd0);
        chk("err_sticky_hold", 32'(bus.bus_err_sticky), 32'd1);
`endif

        // Async reset in the middle of AR_BUSY with one read outstanding
        drive(1'b1, 32'h0000_9000, 1'b0, 1'b0, 32'h0, 2'b00);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00);
        chk("ar_arvalid_before", 32'(bus.arvalid), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("ar_arvalid_drop", 32'(bus.arvalid), 32'd0);
        chk("ar_rready_drop", 32'(bus.rready), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("ar_rready_after", 32'(bus.rready), 32'd0);
        chk("ar_araddr_after", bus.araddr, 32'd0);
`ifdef IBRIDGE_RRESP_ERR_EN
        chk("ar_sticky_cleared", 32'(bus.bus_err_sticky), 32'd0);
`endif
        drive(1'b1, 32'h0000_A000, 1'b1, 1'b0, 32'h0, 2'b00);
        chk("ar_acc", 32'(bus.inst_sram_addr_ok), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h8888_8888, 2'b00);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00);
        chk("ar_cnt_was_zero", 32'(bus.rready), 32'd0);

        // Randomized traffic against a queue model of the fetch port and AXI slave
        m_pend = 1'b0; m_addr = '0; m_cnt = 0;
`ifdef IBRIDGE_RRESP_ERR_EN
        m_sticky = 1'b0;
`endif
        for (int c = 0; c < 800; c++) begin
            req_r = 1'($urandom_range(0, 1));
            a_r   = $urandom() & 32'hFFFF_FFFC;
            arr_r = ($urandom_range(0, 3) != 0);
            if (ar_q.size() != 0) begin
                rv_r = 1'($urandom_range(0, 1));
                rd_r = ar_q[0] ^ DATA_MASK;
            end else begin
                rv_r = (m_cnt == 0) && ($urandom_range(0, 5) == 0);
                rd_r = $urandom();
            end
            rs_r = 2'($urandom_range(0, 3));
            drive(req_r, a_r, arr_r, rv_r, rd_r, rs_r);

            exp_ok  = req_r && !m_pend && (m_cnt < int'(MAX_OUT));
            exp_dok = rv_r && (m_cnt != 0);
            chk("rnd_addr_ok", 32'(bus.inst_sram_addr_ok), 32'(exp_ok));
            chk("rnd_arvalid", 32'(bus.arvalid), 32'(m_pend));
            chk("rnd_rready", 32'(bus.rready), 32'(m_cnt != 0));
            chk("rnd_data_ok", 32'(bus.inst_sram_data_ok), 32'(exp_dok));
            if (m_pend) chk("rnd_araddr", bus.araddr, m_addr);
            if (exp_dok) chk("rnd_rdata", bus.inst_sram_rdata, acc_q[0] ^ DATA_MASK);
`ifdef IBRIDGE_RRESP_ERR_EN
            chk("rnd_rerr", 32'(bus.inst_sram_rerr), 32'(exp_dok && (rs_r != 2'b00)));
            chk("rnd_sticky", 32'(bus.bus_err_sticky), 32'(m_sticky));
            if (exp_dok && (rs_r != 2'b00)) m_sticky = 1'b1;
`endif
            if (exp_dok) begin
                void'(acc_q.pop_front());
                void'(ar_q.pop_front());
            end
            if (m_pend && arr_r) ar_q.push_back(bus.araddr);
            if (exp_ok) begin
                m_pend = 1'b1;
                m_addr = a_r;
                acc_q.push_back(a_r);
            end else if (m_pend && arr_r) begin
                m_pend = 1'b0;
            end
            m_cnt = m_cnt + int'(exp_ok) - int'(exp_dok);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
